// File: rtl/reg_bank.sv
// Small register bank with immediate/bus loads, increment/decrement with flags,
// a shared tristate read bus, and a three-cycle register swap sequencer.
module reg_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             grst_n,
    input  logic             lrst,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    sel,
    input  logic [AW-1:0]    sel2,
    input  logic [WIDTH-1:0] imm,
    inout  wire  [WIDTH-1:0] bus,
    output logic             busy,
    output logic             zf,
    output logic             cf,
    output logic             err
);

    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_WRB = 3'd3;
    localparam logic [2:0] OP_INC = 3'd4;
    localparam logic [2:0] OP_DEC = 3'd5;
    localparam logic [2:0] OP_SWP = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SWP1 = 2'd1;
    localparam logic [1:0] ST_SWP2 = 2'd2;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic             zf_q, zf_d, cf_q, cf_d, err_q, err_d;

    logic [WIDTH-1:0] sel_data, b_data, wr_data;
    logic [WIDTH:0]   inc_sum;
    logic [AW-1:0]    wr_addr;
    logic             wr_en, sel_ok, sel2_ok, idle, needs_sel, reject, drive;

    // Read muxes built from equality compares so out-of-range addresses never index the array.
    always_comb begin
        sel_data = '0;
        b_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == AW'(i)) sel_data = regs_q[i];
            if (b_q == AW'(i)) b_data   = regs_q[i];
        end
    end

    assign sel_ok    = ({1'b0, sel}  < DEPTH_W);
    assign sel2_ok   = ({1'b0, sel2} < DEPTH_W);
    assign idle      = (state_q == ST_IDLE);
    assign needs_sel = (op >= OP_LDI) && (op <= OP_SWP);
    assign reject    = idle && needs_sel && (!sel_ok || (op == OP_SWP && !sel2_ok));
    assign inc_sum   = {1'b0, sel_data} + (WIDTH+1)'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tmp_d   = tmp_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        err_d   = reject;
        wr_en   = 1'b0;
        wr_addr = sel;
        wr_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (!reject) begin
                    unique case (op)
                        OP_LDI: begin
                            wr_en   = 1'b1;
                            wr_data = imm;
                            zf_d    = (imm == '0);
                        end
                        OP_LDB: begin
                            wr_en   = 1'b1;
                            wr_data = bus;
                            zf_d    = (bus == '0);
                        end
                        OP_INC: begin
                            wr_en   = 1'b1;
                            wr_data = inc_sum[WIDTH-1:0];
                            cf_d    = inc_sum[WIDTH];
                            zf_d    = (inc_sum[WIDTH-1:0] == '0);
                        end
                        OP_DEC: begin
                            wr_en   = 1'b1;
                            wr_data = sel_data - WIDTH'(1);
                            cf_d    = (sel_data == '0);
                            zf_d    = (sel_data == WIDTH'(1));
                        end
                        OP_SWP: begin
                            a_d     = sel;
                            b_d     = sel2;
                            tmp_d   = sel_data;
                            state_d = ST_SWP1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SWP1: begin
                wr_en   = 1'b1;
                wr_addr = a_q;
                wr_data = b_data;
                state_d = ST_SWP2;
            end
            ST_SWP2: begin
                wr_en   = 1'b1;
                wr_addr = b_q;
                wr_data = tmp_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && wr_addr == AW'(i)) regs_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!grst_n || lrst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tmp_q   <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tmp_q   <= tmp_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            err_q   <= err_d;
        end
    end

    // Bus is released whenever reset is asserted, even before the edge samples it.
    assign drive = grst_n && !lrst && idle && (op == OP_WRB) && sel_ok;
    assign bus   = drive ? sel_data : 'z;

    assign busy = !idle;
    assign zf   = zf_q;
    assign cf   = cf_q;
    assign err  = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a DEPTH=4 instance for the main function and a
// DEPTH=3 instance for out-of-range rejection. Buses are pulled up so a released bus reads all-ones.
module tb_reg_bank;

    localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, LDB = 3'd2, WRB = 3'd3;
    localparam logic [2:0] INC = 3'd4, DEC = 3'd5, SWP = 3'd6;

    logic       clk = 1'b0;
    logic       grst_n = 1'b0, lrst = 1'b0;
    logic [2:0] op = NOP, op3 = NOP;
    logic [1:0] sel = '0, sel2 = '0, sel3 = '0, sel2_3 = '0;
    logic [3:0] imm = '0, imm3 = '0;
    logic       drv_en = 1'b0;
    logic [3:0] drv_val = '0;
    wire  [3:0] bus, bus3;
    logic       busy, zf, cf, err, busy3, zf3, cf3, err3;
    logic [3:0] rdv;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    assign bus = drv_en ? drv_val : 'z;
    for (genvar i = 0; i < 4; i++) begin : g_pu
        pullup (bus[i]);
        pullup (bus3[i]);
    end

    reg_bank #(.WIDTH(4), .DEPTH(4)) u_dut (
        .clk(clk), .grst_n(grst_n), .lrst(lrst), .op(op), .sel(sel), .sel2(sel2),
        .imm(imm), .bus(bus), .busy(busy), .zf(zf), .cf(cf), .err(err)
    );

    reg_bank #(.WIDTH(4), .DEPTH(3)) u_dut3 (
        .clk(clk), .grst_n(grst_n), .lrst(1'b0), .op(op3), .sel(sel3), .sel2(sel2_3),
        .imm(imm3), .bus(bus3), .busy(busy3), .zf(zf3), .cf(cf3), .err(err3)
    );

    task automatic cmd(input logic [2:0] o, input logic [1:0] s, input logic [1:0] s2, input logic [3:0] v);
        @(negedge clk); op = o; sel = s; sel2 = s2; imm = v;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [1:0] s, output logic [3:0] d);
        @(negedge clk); op = WRB; sel = s; #1;
        d = bus;
    endtask

    task automatic cmd3(input logic [2:0] o, input logic [1:0] s, input logic [1:0] s2, input logic [3:0] v);
        @(negedge clk); op3 = o; sel3 = s; sel2_3 = s2; imm3 = v;
        @(posedge clk); #1;
    endtask

    task automatic rd3(input logic [1:0] s, output logic [3:0] d);
        @(negedge clk); op3 = WRB; sel3 = s; #1;
        d = bus3;
    endtask

    task automatic test_reset();
        grst_n = 1'b0; op = WRB; sel = 2'd2; op3 = WRB; sel3 = 2'd1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if ({busy, zf, cf, err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, zf, cf, err}); end
        checks++; if (bus !== 4'hF) begin failures++; $display("FAIL reset_bus_z got=%h exp=F", bus); end
        checks++; if (bus3 !== 4'hF) begin failures++; $display("FAIL reset_bus3_z got=%h exp=F", bus3); end
        checks++; if ({busy3, zf3, cf3, err3} !== 4'b0) begin failures++; $display("FAIL reset_flags3 got=%b exp=0000", {busy3, zf3, cf3, err3}); end
        @(negedge clk); grst_n = 1'b1; op = NOP; op3 = NOP;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), rdv);
            checks++; if (rdv !== 4'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", i, rdv); end
        end
    endtask

    task automatic test_ldi_wrb();
        cmd(LDI, 2'd0, 2'd0, 4'h0);
        checks++; if (zf !== 1'b1) begin failures++; $display("FAIL ldi_zero_zf got=%b exp=1", zf); end
        cmd(LDI, 2'd2, 2'd0, 4'hA);
        checks++; if (zf !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL ldi_a_flags got=%b%b exp=00", zf, err); end
        rd(2'd2, rdv);
        checks++; if (rdv !== 4'hA) begin failures++; $display("FAIL wrb_r2 got=%h exp=A", rdv); end
        cmd(NOP, 2'd2, 2'd0, 4'h0);
        checks++; if (bus !== 4'hF) begin failures++; $display("FAIL nop_bus_z got=%h exp=F", bus); end
        checks++; if (zf !== 1'b0) begin failures++; $display("FAIL wrb_keeps_zf got=%b exp=0", zf); end
    endtask

    task automatic test_inc_dec();
        cmd(LDI, 2'd1, 2'd0, 4'hF);
        cmd(INC, 2'd1, 2'd0, 4'h0);
        checks++; if ({cf, zf} !== 2'b11) begin failures++; $display("FAIL inc_wrap_flags got=%b%b exp=11", cf, zf); end
        rd(2'd1, rdv);
        checks++; if (rdv !== 4'h0) begin failures++; $display("FAIL inc_wrap_val got=%h exp=0", rdv); end
        cmd(DEC, 2'd1, 2'd0, 4'h0);
        checks++; if ({cf, zf} !== 2'b10) begin failures++; $display("FAIL dec_wrap_flags got=%b%b exp=10", cf, zf); end
        rd(2'd1, rdv);
        checks++; if (rdv !== 4'hF) begin failures++; $display("FAIL dec_wrap_val got=%h exp=F", rdv); end
        cmd(LDI, 2'd3, 2'd0, 4'h5);
        cmd(INC, 2'd3, 2'd0, 4'h0);
        checks++; if ({cf, zf} !== 2'b00) begin failures++; $display("FAIL inc_plain_flags got=%b%b exp=00", cf, zf); end
        rd(2'd3, rdv);
        checks++; if (rdv !== 4'h6) begin failures++; $display("FAIL inc_plain_val got=%h exp=6", rdv); end
        cmd(LDI, 2'd3, 2'd0, 4'h1);
        cmd(DEC, 2'd3, 2'd0, 4'h0);
        checks++; if ({cf, zf} !== 2'b01) begin failures++; $display("FAIL dec_to_zero_flags got=%b%b exp=01", cf, zf); end
    endtask

    task automatic test_ldb();
        cmd(INC, 2'd1, 2'd0, 4'h0);   // R1 F->0 sets cf
        cmd(LDI, 2'd0, 2'd0, 4'h6);
        drv_en = 1'b1; drv_val = 4'h0;
        cmd(LDB, 2'd0, 2'd0, 4'h0);
        checks++; if ({cf, zf} !== 2'b11) begin failures++; $display("FAIL ldb_zero_flags got=%b%b exp=11", cf, zf); end
        drv_val = 4'h9;
        cmd(LDB, 2'd3, 2'd0, 4'h0);
        drv_en = 1'b0;
        checks++; if ({cf, zf} !== 2'b10) begin failures++; $display("FAIL ldb_nine_flags got=%b%b exp=10", cf, zf); end
        rd(2'd0, rdv);
        checks++; if (rdv !== 4'h0) begin failures++; $display("FAIL ldb_r0 got=%h exp=0", rdv); end
        rd(2'd3, rdv);
        checks++; if (rdv !== 4'h9) begin failures++; $display("FAIL ldb_r3 got=%h exp=9", rdv); end
    endtask

    task automatic test_swp();
        cmd(LDI, 2'd3, 2'd0, 4'hC);
        cmd(LDI, 2'd0, 2'd0, 4'h3);
        cmd(LDI, 2'd1, 2'd0, 4'h0);   // zf=1, cf still 1
        cmd(SWP, 2'd0, 2'd3, 4'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swp_busy1 got=%b exp=1", busy); end
        cmd(LDI, 2'd0, 2'd0, 4'h5);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swp_busy2 got=%b exp=1", busy); end
        cmd(NOP, 2'd0, 2'd0, 4'h0);
        checks++; if ({busy, zf, cf, err} !== 4'b0110) begin failures++; $display("FAIL swp_done_flags got=%b exp=0110", {busy, zf, cf, err}); end
        rd(2'd0, rdv);
        checks++; if (rdv !== 4'hC) begin failures++; $display("FAIL swp_r0 got=%h exp=C", rdv); end
        rd(2'd3, rdv);
        checks++; if (rdv !== 4'h3) begin failures++; $display("FAIL swp_r3 got=%h exp=3", rdv); end
        cmd(SWP, 2'd2, 2'd2, 4'h0);
        cmd(NOP, 2'd0, 2'd0, 4'h0);
        cmd(NOP, 2'd0, 2'd0, 4'h0);
        rd(2'd2, rdv);
        checks++; if (rdv !== 4'hA) begin failures++; $display("FAIL swp_self_r2 got=%h exp=A", rdv); end
    endtask

    task automatic test_lrst();
        @(negedge clk); lrst = 1'b1; op = LDI; sel = 2'd1; imm = 4'h7;
        @(posedge clk); #1;
        checks++; if ({busy, zf, cf, err} !== 4'b0) begin failures++; $display("FAIL lrst_flags got=%b exp=0000", {busy, zf, cf, err}); end
        @(negedge clk); op = WRB; sel = 2'd2; #1;
        checks++; if (bus !== 4'hF) begin failures++; $display("FAIL lrst_bus_z got=%h exp=F", bus); end
        @(negedge clk); lrst = 1'b0; op = NOP;
        rd(2'd1, rdv);
        checks++; if (rdv !== 4'h0) begin failures++; $display("FAIL lrst_r1 got=%h exp=0", rdv); end
        rd(2'd2, rdv);
        checks++; if (rdv !== 4'h0) begin failures++; $display("FAIL lrst_r2 got=%h exp=0", rdv); end
    endtask

    task automatic test_reset_swp2();
        cmd(LDI, 2'd0, 2'd0, 4'h3);
        cmd(LDI, 2'd1, 2'd0, 4'h5);
        cmd(LDI, 2'd2, 2'd0, 4'hF);
        cmd(INC, 2'd2, 2'd0, 4'h0);
        cmd(SWP, 2'd0, 2'd1, 4'h0);
        cmd(NOP, 2'd0, 2'd0, 4'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swp2_busy got=%b exp=1", busy); end
        @(negedge clk); grst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, zf, cf, err} !== 4'b0) begin failures++; $display("FAIL swp2_rst_flags got=%b exp=0000", {busy, zf, cf, err}); end
        @(negedge clk); grst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(2'(i), rdv);
            checks++; if (rdv !== 4'h0) begin failures++; $display("FAIL swp2_rst_reg%0d got=%h exp=0", i, rdv); end
        end
    endtask

    task automatic test_depth3_reject();
        cmd3(LDI, 2'd1, 2'd0, 4'h7);
        cmd3(LDI, 2'd0, 2'd0, 4'h0);
        checks++; if ({zf3, err3} !== 2'b10) begin failures++; $display("FAIL d3_setup got=%b%b exp=10", zf3, err3); end
        @(negedge clk); op3 = LDI; sel3 = 2'd3; imm3 = 4'h5; #1;
        checks++; if (bus3 !== 4'hF) begin failures++; $display("FAIL d3_ldi_bus_z got=%h exp=F", bus3); end
        @(posedge clk); #1;
        checks++; if ({err3, zf3, busy3} !== 3'b110) begin failures++; $display("FAIL d3_ldi_reject got=%b exp=110", {err3, zf3, busy3}); end
        cmd3(NOP, 2'd0, 2'd0, 4'h0);
        checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL d3_err_pulse got=%b exp=0", err3); end
        rd3(2'd3, rdv);
        checks++; if (rdv !== 4'hF) begin failures++; $display("FAIL d3_wrb_bus_z got=%h exp=F", rdv); end
        @(posedge clk); #1;
        checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL d3_wrb_err got=%b exp=1", err3); end
        cmd3(SWP, 2'd0, 2'd3, 4'h0);
        checks++; if ({err3, busy3} !== 2'b10) begin failures++; $display("FAIL d3_swp_reject got=%b exp=10", {err3, busy3}); end
        cmd3(NOP, 2'd0, 2'd0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            rd3(2'(i), rdv);
            checks++; if (rdv !== ((i == 1) ? 4'h7 : 4'h0)) begin failures++; $display("FAIL d3_reg%0d got=%h exp=%h", i, rdv, (i == 1) ? 4'h7 : 4'h0); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ldi_wrb();
        test_inc_dec();
        test_ldb();
        test_swp();
        test_lrst();
        test_reset_swp2();
        test_depth3_reject();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
